// File: rtl/sext_lane_unpack.sv
// Unpacks a word of LANES narrow lanes into INW-bit sign- or zero-extended
// lanes, presenting one lane per valid/ready transfer with no bubble between words.
module sext_lane_unpack #(
  parameter int OUTW  = 8,
  parameter int INW   = 16,
  parameter int LANES = 4,
  localparam int LW   = $clog2(LANES)
) (
  input  logic                  i_clk,
  input  logic                  i_nRst,
  input  logic                  i_flush,
  input  logic                  i_wordValid,
  output logic                  o_wordReady,
  input  logic [LANES*OUTW-1:0] i_word,
  input  logic                  i_zeroExt,
  input  logic [LW-1:0]         i_lastLane,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INW-1:0]        o_value,
  output logic [LW-1:0]         o_laneIdx,
  output logic                  o_last
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [LW-1:0]         last_q, last_d;
  logic [LANES*OUTW-1:0] word_q, word_d;
  logic                  zext_q, zext_d;
  logic [OUTW-1:0]       lane_bits_s;
  logic                  accept_s;
  logic                  xfer_s;

  // Select the current lane and decode the stream handshakes from state.
  always_comb begin
    lane_bits_s = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == LW'(k)) begin
        lane_bits_s = word_q[k*OUTW +: OUTW];
      end else begin
        lane_bits_s = lane_bits_s;
      end
    end
    o_valid   = (state_q == S_EMIT);
    o_last    = o_valid & (lane_q == last_q);
    o_laneIdx = lane_q;
    o_value   = {{(INW-OUTW){lane_bits_s[OUTW-1] & ~zext_q}}, lane_bits_s};
    // A new word may enter while the final lane of the previous one is taken.
    o_wordReady = i_nRst & ~i_flush & (~o_valid | (o_last & i_ready));
    accept_s    = i_wordValid & o_wordReady;
    xfer_s      = o_valid & i_ready & i_nRst & ~i_flush;
  end

  // Next-state: flush beats accept, accept beats plain lane advance.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    last_d  = last_q;
    word_d  = word_q;
    zext_d  = zext_q;
    if (i_flush) begin
      state_d = S_IDLE;
      lane_d  = '0;
    end else if (accept_s) begin
      state_d = S_EMIT;
      lane_d  = '0;
      word_d  = i_word;
      zext_d  = i_zeroExt;
      last_d  = i_lastLane;
    end else if (xfer_s) begin
      if (o_last) begin
        state_d = S_IDLE;
        lane_d  = '0;
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and held-word registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_nRst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      last_q  <= '0;
      word_q  <= '0;
      zext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      word_q  <= word_d;
      zext_q  <= zext_d;
    end
  end

endmodule

// File: tb/tb_sext_lane_unpack.sv
// Directed bench for sext_lane_unpack with a queue-based reference model
// checked against the DUT on every falling edge.
module tb_sext_lane_unpack;

  logic        i_clk = 1'b0;
  logic        i_nRst = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_wordValid = 1'b0;
  logic        o_wordReady;
  logic [31:0] i_word = 32'h0;
  logic        i_zeroExt = 1'b0;
  logic [1:0]  i_lastLane = 2'd0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [15:0] o_value;
  logic [1:0]  o_laneIdx;
  logic        o_last;

  sext_lane_unpack #(.OUTW(8), .INW(16), .LANES(4)) dut (
    .i_clk(i_clk), .i_nRst(i_nRst), .i_flush(i_flush),
    .i_wordValid(i_wordValid), .o_wordReady(o_wordReady),
    .i_word(i_word), .i_zeroExt(i_zeroExt), .i_lastLane(i_lastLane),
    .o_valid(o_valid), .i_ready(i_ready), .o_value(o_value),
    .o_laneIdx(o_laneIdx), .o_last(o_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] v;
    logic [1:0]  idx;
    logic        last;
  } lane_t;

  lane_t       mq[$];
  logic [15:0] got[$];
  int          nerr = 0;
  int          nchk = 0;
  int          vcyc = 0;
  bit          chk_en = 1'b0;

  localparam logic [31:0] WORD_A = 32'h807FFF01;
  localparam logic [31:0] WORD_B = 32'hFE027F81;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Widen one narrow lane arithmetically.
  function automatic logic [15:0] ext(logic [31:0] w, int k, logic z);
    int u;
    u = int'(w[k*8 +: 8]);
    if (!z && u >= 128) u = u - 256;
    return u[15:0];
  endfunction

  function automatic logic exp_rdy();
    return i_nRst && !i_flush && (mq.size() == 0 || (mq.size() == 1 && i_ready));
  endfunction

  // Reference model: queue of lanes still owed by the accepted word.
  always @(posedge i_clk) begin
    logic rdy;
    lane_t e;
    chk_en = 1'b1;
    rdy = exp_rdy();
    if (!i_nRst || i_flush) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && i_ready) void'(mq.pop_front());
      if (i_wordValid && rdy) begin
        for (int k = 0; k <= int'(i_lastLane); k++) begin
          e.v = ext(i_word, k, i_zeroExt);
          e.idx = 2'(k);
          e.last = (k == int'(i_lastLane));
          mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus transfer logging.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("valid", {31'd0, o_valid}, {31'd0, mq.size() != 0});
      chk("wordReady", {31'd0, o_wordReady}, {31'd0, exp_rdy()});
      if (mq.size() != 0) begin
        chk("value", {16'd0, o_value}, {16'd0, mq[0].v});
        chk("laneIdx", {30'd0, o_laneIdx}, {30'd0, mq[0].idx});
        chk("last", {31'd0, o_last}, {31'd0, mq[0].last});
      end
      if (o_valid) vcyc++;
      if (o_valid && i_ready && i_nRst && !i_flush) got.push_back(o_value);
    end
  end

  task automatic send(logic [31:0] w, logic z, logic [1:0] l, logic [15:0] first);
    bit ok = 1'b0;
    i_word = w; i_zeroExt = z; i_lastLane = l; i_wordValid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge i_clk);
      if (o_wordReady) ok = 1'b1;
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge i_clk); #1;
    i_wordValid = 1'b0;
    chk("lat_valid", {31'd0, o_valid}, 32'd1);
    chk("lat_value", {16'd0, o_value}, {16'd0, first});
    chk("lat_idx", {30'd0, o_laneIdx}, 32'd0);
  endtask

  task automatic wait_got(int n);
    for (int i = 0; i < 50 && got.size() < n; i++) @(posedge i_clk);
    #1;
    chk("drain_timeout", {31'd0, got.size() >= n}, 32'd1);
  endtask

  task automatic check_got(string nm, int base, logic [63:0] exp4);
    logic [15:0] act;
    for (int k = 0; k < 4; k++) begin
      act = (base + k < got.size()) ? got[base + k] : 16'hxxxx;
      chk(nm, {16'd0, act}, {16'd0, exp4[k*16 +: 16]});
    end
  endtask

  initial begin
    bit ok;
    // Reset held with a word offered.
    i_nRst = 1'b0; i_wordValid = 1'b1; i_word = WORD_A;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_wready", {31'd0, o_wordReady}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_value", {16'd0, o_value}, 32'd0);
    chk("rst_idx", {30'd0, o_laneIdx}, 32'd0);
    chk("rst_last", {31'd0, o_last}, 32'd0);
    i_wordValid = 1'b0; i_nRst = 1'b1;
    #1;
    chk("idle_wready", {31'd0, o_wordReady}, 32'd1);

    // Sign extension.
    got.delete();
    send(WORD_A, 1'b0, 2'd3, 16'h0001);
    wait_got(4);
    check_got("sign_seq", 0, 64'hFF80_007F_FFFF_0001);

    // Zero extension.
    got.delete();
    send(WORD_A, 1'b1, 2'd3, 16'h0001);
    wait_got(4);
    check_got("zero_seq", 0, 64'h0080_007F_00FF_0001);

    // Backpressure on lane 1.
    got.delete();
    send(WORD_A, 1'b0, 2'd3, 16'h0001);
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      chk("bp_value", {16'd0, o_value}, 32'h0000FFFF);
      chk("bp_idx", {30'd0, o_laneIdx}, 32'd1);
    end
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    wait_got(4);
    chk("bp_count", got.size(), 32'd4);
    check_got("bp_seq", 0, 64'hFF80_007F_FFFF_0001);

    // Back-to-back words, second one zero-extended.
    @(posedge i_clk); #1;
    got.delete(); vcyc = 0;
    i_word = WORD_A; i_zeroExt = 1'b0; i_lastLane = 2'd3; i_wordValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge i_clk);
      if (o_wordReady) ok = 1'b1;
    end
    @(posedge i_clk); #1;
    i_word = WORD_B; i_zeroExt = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge i_clk);
      if (o_wordReady) ok = 1'b1;
    end
    chk("b2b_accept", {31'd0, ok}, 32'd1);
    chk("b2b_on_last", {31'd0, o_last}, 32'd1);
    @(posedge i_clk); #1;
    i_wordValid = 1'b0;
    wait_got(8);
    chk("b2b_vcycles", vcyc, 32'd8);
    check_got("b2b_seq_a", 0, 64'hFF80_007F_FFFF_0001);
    check_got("b2b_seq_b", 4, 64'h00FE_0002_007F_0081);
    @(posedge i_clk); #1;
    chk("b2b_idle", {31'd0, o_valid}, 32'd0);

    // Partial word: lanes 0..1 only.
    got.delete();
    send(WORD_A, 1'b0, 2'd1, 16'h0001);
    wait_got(2);
    repeat (2) @(posedge i_clk);
    #1;
    chk("part_count", got.size(), 32'd2);
    chk("part_l1", {16'd0, got.size() > 1 ? got[1] : 16'hxxxx}, 32'h0000FFFF);
    chk("part_idle", {31'd0, o_valid}, 32'd0);

    // Flush while lane 2 is shown.
    got.delete();
    send(WORD_A, 1'b0, 2'd3, 16'h0001);
    repeat (2) begin
      @(posedge i_clk); #1;
    end
    chk("fl_idx", {30'd0, o_laneIdx}, 32'd2);
    i_flush = 1'b1;
    #1;
    chk("fl_wready", {31'd0, o_wordReady}, 32'd0);
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("fl_valid", {31'd0, o_valid}, 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("fl_quiet", {31'd0, o_valid}, 32'd0);
    chk("fl_count", got.size(), 32'd2);

    // Reset while lane 1 is shown.
    got.delete();
    send(WORD_A, 1'b0, 2'd3, 16'h0001);
    @(posedge i_clk); #1;
    chk("mr_idx", {30'd0, o_laneIdx}, 32'd1);
    i_nRst = 1'b0;
    @(posedge i_clk); #1;
    chk("mr_valid", {31'd0, o_valid}, 32'd0);
    chk("mr_value", {16'd0, o_value}, 32'd0);
    chk("mr_idx0", {30'd0, o_laneIdx}, 32'd0);
    chk("mr_last", {31'd0, o_last}, 32'd0);
    chk("mr_wready", {31'd0, o_wordReady}, 32'd0);
    i_nRst = 1'b1;
    @(posedge i_clk); #1;
    chk("mr_after", {31'd0, o_valid}, 32'd0);
    chk("mr_count", got.size(), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1);
  end

endmodule
